// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - state encoding, coin denominations and coin-sum helper for the vending controller
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PAY    = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3
    } state_t;

    localparam int N_DENOM = 5;

    localparam logic [2:0] DENOM_1  = 3'd0;
    localparam logic [2:0] DENOM_5  = 3'd1;
    localparam logic [2:0] DENOM_10 = 3'd2;
    localparam logic [2:0] DENOM_20 = 3'd3;
    localparam logic [2:0] DENOM_50 = 3'd4;

    // Yuan value of each denomination index; entry 0 is the 1-yuan coin.
    localparam logic [N_DENOM-1:0][5:0] DENOM_VAL = {6'd50, 6'd20, 6'd10, 6'd5, 6'd1};

    // Total value of every coin bit asserted in one cycle (at most 86).
    function automatic logic [6:0] coin_sum(input logic [N_DENOM-1:0] pulses);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < N_DENOM; i++) begin
            if (pulses[i]) s = s + 7'(DENOM_VAL[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/vend_change_disp.sv
// rtl/vend_change_disp.sv - greedy change dispenser with coin-out handshake
// Ports: sys_clk/sys_rst clock and sync active-high reset; load/load_val preset the change
// amount; active enables dispensing; coin_out_valid/denom/ready coin handshake;
// change_money remaining amount; change_zero flags nothing left to pay out.
module vend_change_disp
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
)
(
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                active,
    output logic                coin_out_valid,
    output logic [2:0]          coin_out_denom,
    input  logic                coin_out_ready,
    output logic [CREDIT_W-1:0] change_money,
    output logic                change_zero
);

    logic [CREDIT_W-1:0] amt;
    logic [2:0]          denom;

    function automatic logic fits(input logic [CREDIT_W-1:0] a, input logic [2:0] d);
        return int'(a) >= int'(DENOM_VAL[d]);
    endfunction

    // Denomination is a pure function of the remaining amount, which only moves on an
    // accepted coin, so it stays stable while a coin is waiting for ready.
    always_comb begin
        if (fits(amt, DENOM_50))      denom = DENOM_50;
        else if (fits(amt, DENOM_20)) denom = DENOM_20;
        else if (fits(amt, DENOM_10)) denom = DENOM_10;
        else if (fits(amt, DENOM_5))  denom = DENOM_5;
        else                          denom = DENOM_1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            amt <= '0;
        end else if (load) begin
            amt <= load_val;
        end else if (coin_out_valid && coin_out_ready) begin
            amt <= amt - CREDIT_W'(DENOM_VAL[denom]);
        end
    end

    assign coin_out_valid = active && (amt != '0);
    assign coin_out_denom = denom;
    assign change_money   = amt;
    assign change_zero    = (amt == '0);

endmodule

// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - vending machine transaction controller (select, pay, vend, change)
// Ports: sys_clk/sys_rst clock and sync active-high reset; coin_pulse coin inputs;
// sel_slot/sel_qty/price_flat selection and prices; btn_confirm/btn_cancel/stock_load
// pulses; state_out/need_money/input_money/change_money status; vend_* dispense
// handshake; coin_out_* change handshake; err_stock/coin_reject error pulses.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int N_SLOTS     = 4,
    parameter int PRICE_W     = 5,
    parameter int QTY_W       = 2,
    parameter int CREDIT_W    = 8,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 9,
    parameter int TIMEOUT_CYC = 500000000
)
(
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [4:0]                   coin_pulse,
    input  logic [$clog2(N_SLOTS)-1:0]   sel_slot,
    input  logic [QTY_W-1:0]             sel_qty,
    input  logic [N_SLOTS*PRICE_W-1:0]   price_flat,
    input  logic                         btn_confirm,
    input  logic                         btn_cancel,
    input  logic                         stock_load,
    output logic [2:0]                   state_out,
    output logic [PRICE_W+QTY_W-1:0]     need_money,
    output logic [CREDIT_W-1:0]          input_money,
    output logic [CREDIT_W-1:0]          change_money,
    output logic                         vend_valid,
    output logic [$clog2(N_SLOTS)-1:0]   vend_slot,
    output logic [QTY_W-1:0]             vend_qty,
    input  logic                         vend_ready,
    output logic                         coin_out_valid,
    output logic [2:0]                   coin_out_denom,
    input  logic                         coin_out_ready,
    output logic                         err_stock,
    output logic                         coin_reject
);

    localparam int SLOT_W = $clog2(N_SLOTS);
    localparam int NEED_W = PRICE_W + QTY_W;
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    // Wide enough for credit plus one cycle of coins, so overflow is visible.
    localparam int SUM_W  = ((CREDIT_W > 7) ? CREDIT_W : 7) + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'({CREDIT_W{1'b1}});
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

    state_t              state, state_nxt;
    logic [SLOT_W-1:0]   slot_q;
    logic [QTY_W-1:0]    qty_q;
    logic [NEED_W-1:0]   need_q;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock [N_SLOTS];
    logic [TMO_W-1:0]    tmo_cnt;

    logic [6:0]          coin_val;
    logic                coin_any, coin_ok, tmo_hit, stock_ok;
    logic [SUM_W-1:0]    credit_sum;
    logic [CREDIT_W-1:0] credit_eff;
    logic [PRICE_W-1:0]  sel_price;
    logic [NEED_W-1:0]   sel_need;
    logic                start_txn, stock_short, pay_confirm, pay_cancel;
    logic [CREDIT_W-1:0] chg_load_val;
    logic                change_zero;

    assign coin_val   = coin_sum(coin_pulse);
    assign coin_any   = |coin_pulse;
    assign credit_sum = SUM_W'(credit) + SUM_W'(coin_val);
    assign coin_ok    = coin_any && (state == ST_PAY) && (credit_sum <= CREDIT_MAX);
    // Coins accepted this cycle count before confirm/cancel, so they are refunded on cancel.
    assign credit_eff = coin_ok ? credit_sum[CREDIT_W-1:0] : credit;
    assign tmo_hit    = !coin_ok && (tmo_cnt == TMO_LAST);
    assign sel_price  = price_flat[sel_slot*PRICE_W +: PRICE_W];
    assign sel_need   = NEED_W'(sel_price) * NEED_W'(sel_qty);
    assign stock_ok   = int'(stock[sel_slot]) >= int'(sel_qty);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_txn    = 1'b0;
        stock_short  = 1'b0;
        pay_confirm  = 1'b0;
        pay_cancel   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (btn_confirm && (sel_qty != '0)) begin
                    if (stock_ok) begin
                        start_txn = 1'b1;
                        state_nxt = ST_PAY;
                    end else begin
                        stock_short = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (btn_cancel || tmo_hit) begin
                    pay_cancel = 1'b1;
                    state_nxt  = ST_CHANGE;
                end else if (btn_confirm && (SUM_W'(credit_eff) >= SUM_W'(need_q))) begin
                    pay_confirm = 1'b1;
                    state_nxt   = ST_VEND;
                end
            end
            ST_VEND: begin
                if (vend_ready) state_nxt = ST_CHANGE;
            end
            ST_CHANGE: begin
                if (change_zero) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign chg_load_val = pay_confirm ? (credit_eff - CREDIT_W'(need_q)) : credit_eff;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            slot_q      <= '0;
            qty_q       <= '0;
            need_q      <= '0;
            credit      <= '0;
            tmo_cnt     <= '0;
            err_stock   <= 1'b0;
            coin_reject <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            err_stock   <= stock_short;
            coin_reject <= coin_any && !coin_ok;
            if (coin_ok) credit <= credit_sum[CREDIT_W-1:0];

            if (start_txn || coin_ok)                           tmo_cnt <= '0;
            else if ((state == ST_PAY) && (tmo_cnt != TMO_LAST)) tmo_cnt <= tmo_cnt + 1'b1;

            if (start_txn) begin
                slot_q <= sel_slot;
                qty_q  <= sel_qty;
                need_q <= sel_need;
                credit <= '0;
            end
            if (pay_confirm) stock[slot_q] <= stock[slot_q] - STOCK_W'(qty_q);
            if ((state == ST_CHANGE) && change_zero) begin
                credit <= '0;
                need_q <= '0;
            end
            if ((state == ST_IDLE) && stock_load) begin
                for (int i = 0; i < N_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end
    end

    vend_change_disp #(.CREDIT_W(CREDIT_W)) u_change (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .load           (pay_confirm || pay_cancel),
        .load_val       (chg_load_val),
        .active         (state == ST_CHANGE),
        .coin_out_valid (coin_out_valid),
        .coin_out_denom (coin_out_denom),
        .coin_out_ready (coin_out_ready),
        .change_money   (change_money),
        .change_zero    (change_zero)
    );

    assign state_out   = state;
    assign need_money  = need_q;
    assign input_money = credit;
    assign vend_valid  = (state == ST_VEND);
    assign vend_slot   = slot_q;
    assign vend_qty    = qty_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb/tb_vend_txn_ctrl.sv - self-checking bench for vend_txn_ctrl with a transaction-level model
module tb_vend_txn_ctrl;

    localparam int N_SLOTS = 4;
    localparam int PRICE_W = 5;
    localparam int TMO     = 20;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [4:0]   coin_pulse = '0;
    logic [1:0]   sel_slot = '0;
    logic [1:0]   sel_qty = '0;
    logic [19:0]  price_flat = '0;
    logic         btn_confirm = 1'b0, btn_cancel = 1'b0, stock_load = 1'b0;
    logic         vend_ready = 1'b0, coin_out_ready = 1'b0;
    logic [2:0]   state_out;
    logic [6:0]   need_money;
    logic [7:0]   input_money, change_money;
    logic         vend_valid, coin_out_valid, err_stock, coin_reject;
    logic [1:0]   vend_slot, vend_qty;
    logic [2:0]   coin_out_denom;

    always #5 sys_clk = ~sys_clk;

    vend_txn_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .coin_pulse(coin_pulse),
        .sel_slot(sel_slot), .sel_qty(sel_qty), .price_flat(price_flat),
        .btn_confirm(btn_confirm), .btn_cancel(btn_cancel), .stock_load(stock_load),
        .state_out(state_out), .need_money(need_money), .input_money(input_money),
        .change_money(change_money), .vend_valid(vend_valid), .vend_slot(vend_slot),
        .vend_qty(vend_qty), .vend_ready(vend_ready), .coin_out_valid(coin_out_valid),
        .coin_out_denom(coin_out_denom), .coin_out_ready(coin_out_ready),
        .err_stock(err_stock), .coin_reject(coin_reject)
    );

    int total = 0;
    int bad = 0;
    int m_stock [N_SLOTS];
    int m_price [N_SLOTS];
    int vals [5] = '{1, 5, 10, 20, 50};
    int coin_seq [$];
    int exp_d [$];
    int got_d [$];
    int n_vend, v_slot, v_qty;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_price(input int slot, input int p);
        price_flat[slot*PRICE_W +: PRICE_W] = 5'(p);
        m_price[slot] = p;
    endtask

    task automatic model_reload();
        for (int i = 0; i < N_SLOTS; i++) m_stock[i] = 9;
    endtask

    task automatic do_stock_load();
        stock_load = 1'b1; tick(); stock_load = 1'b0;
        model_reload();
    endtask

    function automatic int coin_value(input int c);
        int s;
        s = 0;
        for (int i = 0; i < 5; i++) if (c[i]) s += vals[i];
        return s;
    endfunction

    task automatic greedy(input int amt);
        exp_d.delete();
        for (int i = 4; i >= 0; i--) begin
            while (amt >= vals[i]) begin
                exp_d.push_back(i);
                amt -= vals[i];
            end
        end
    endtask

    task automatic drain();
        n_vend = 0; v_slot = -1; v_qty = -1;
        got_d.delete();
        vend_ready = 1'b1; coin_out_ready = 1'b1;
        for (int i = 0; i < 60 && state_out != 3'd0; i++) begin
            if (vend_valid) begin n_vend++; v_slot = vend_slot; v_qty = vend_qty; end
            if (coin_out_valid) got_d.push_back(int'(coin_out_denom));
            tick();
        end
        vend_ready = 1'b0; coin_out_ready = 1'b0;
        chk("drain_back_idle", state_out, 0);
    endtask

    // action: 0 confirm (cancel if short of credit), 1 cancel, 2 cancel+confirm, 3 wait for timeout
    task automatic do_txn(input int slot, input int qty, input int action);
        int need, credit, idle, s, chg, ev;
        sel_slot = 2'(slot); sel_qty = 2'(qty);
        btn_confirm = 1'b1; tick(); btn_confirm = 1'b0;
        if (qty == 0) begin
            chk("qty0_state", state_out, 0);
            chk("qty0_err", err_stock, 0);
            return;
        end
        if (m_stock[slot] < qty) begin
            chk("short_err", err_stock, 1);
            chk("short_state", state_out, 0);
            tick();
            chk("short_err_clear", err_stock, 0);
            return;
        end
        need = m_price[slot] * qty; credit = 0; idle = 0; ev = 0;
        chk("pay_state", state_out, 1);
        chk("pay_need", need_money, need);
        chk("pay_credit0", input_money, 0);
        foreach (coin_seq[i]) begin
            coin_pulse = 5'(coin_seq[i]); tick(); coin_pulse = '0;
            s = coin_value(coin_seq[i]);
            if (s != 0 && credit + s <= 255) begin
                credit += s; idle = 0;
                chk("coin_reject", coin_reject, 0);
            end else begin
                idle++;
                chk("coin_reject", coin_reject, 32'(s != 0));
            end
            chk("credit", input_money, credit);
        end
        if (action == 0) begin
            btn_confirm = 1'b1; tick(); btn_confirm = 1'b0;
            if (credit >= need) begin
                ev = 1; chg = credit - need; m_stock[slot] -= qty;
                chk("to_vend", state_out, 2);
            end else begin
                chk("short_credit_stay", state_out, 1);
                btn_cancel = 1'b1; tick(); btn_cancel = 1'b0;
                chg = credit;
                chk("to_change", state_out, 3);
            end
        end else if (action == 3) begin
            repeat (TMO - 1 - idle) tick();
            chk("tmo_hold", state_out, 1);
            tick();
            chk("tmo_fire", state_out, 3);
            chg = credit;
        end else begin
            btn_cancel = 1'b1;
            if (action == 2) btn_confirm = 1'b1;
            tick();
            btn_cancel = 1'b0; btn_confirm = 1'b0;
            chk("cancel_state", state_out, 3);
            chg = credit;
        end
        chk("change_amt", change_money, chg);
        greedy(chg);
        drain();
        chk("vend_count", n_vend, ev);
        if (ev != 0) begin
            chk("vend_slot", v_slot, slot);
            chk("vend_qty", v_qty, qty);
        end
        chk("coin_count", got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) chk("coin_denom", got_d[i], exp_d[i]);
        chk("end_credit", input_money, 0);
        chk("end_need", need_money, 0);
        chk("end_change", change_money, 0);
    endtask

    initial begin
        int n;
        model_reload();
        for (int k = 0; k < N_SLOTS; k++) set_price(k, 1);
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        chk("rst_state", state_out, 0);
        chk("rst_credit", input_money, 0);
        chk("rst_need", need_money, 0);
        chk("rst_change", change_money, 0);
        chk("rst_vend_valid", vend_valid, 0);
        chk("rst_coin_valid", coin_out_valid, 0);
        chk("rst_err", err_stock, 0);
        chk("rst_reject", coin_reject, 0);

        coin_pulse = 5'b00100; tick(); coin_pulse = '0;
        chk("idle_coin_reject", coin_reject, 1);
        chk("idle_coin_credit", input_money, 0);
        tick();
        chk("idle_coin_reject_clear", coin_reject, 0);

        set_price(1, 7);
        coin_seq = '{4, 2};
        do_txn(1, 2, 0);

        set_price(0, 31);
        coin_seq = '{16, 16, 16, 16, 16, 4};
        do_txn(0, 3, 1);

        set_price(2, 3);
        coin_seq = '{24};
        do_txn(2, 1, 2);

        coin_seq = '{2};
        do_txn(3, 1, 3);

        coin_seq = '{16};
        do_txn(1, 3, 0);
        do_txn(1, 3, 0);
        do_txn(1, 2, 0);
        do_stock_load();
        do_txn(1, 3, 0);
        do_txn(1, 3, 0);
        do_txn(1, 3, 0);
        do_txn(1, 1, 0);
        do_stock_load();

        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < N_SLOTS; k++) set_price(k, int'($urandom_range(1, 31)));
            if ($urandom_range(0, 4) == 0) do_stock_load();
            coin_seq.delete();
            n = int'($urandom_range(0, 6));
            repeat (n) begin
                if ($urandom_range(0, 2) == 0) coin_seq.push_back(int'($urandom_range(0, 31)));
                else coin_seq.push_back(1 << $urandom_range(0, 4));
            end
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        do_stock_load();
        sel_slot = 2'd2; sel_qty = 2'd1;
        btn_confirm = 1'b1; tick(); btn_confirm = 1'b0;
        coin_pulse = 5'b11000; tick(); coin_pulse = '0;
        btn_cancel = 1'b1; tick(); btn_cancel = 1'b0;
        chk("hold_state", state_out, 3);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", coin_out_valid, 1);
            chk("hold_denom", coin_out_denom, 4);
            chk("hold_change", change_money, 70);
            tick();
        end
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        model_reload();
        chk("rst_chg_state", state_out, 0);
        chk("rst_chg_valid", coin_out_valid, 0);
        chk("rst_chg_change", change_money, 0);
        chk("rst_chg_credit", input_money, 0);
        chk("rst_chg_need", need_money, 0);

        set_price(0, 5);
        sel_slot = 2'd0; sel_qty = 2'd1;
        btn_confirm = 1'b1; tick(); btn_confirm = 1'b0;
        coin_pulse = 5'b10000; tick(); coin_pulse = '0;
        btn_confirm = 1'b1; tick(); btn_confirm = 1'b0;
        tick();
        chk("vend_wait_valid", vend_valid, 1);
        chk("vend_wait_slot", vend_slot, 0);
        chk("vend_wait_change", change_money, 45);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        chk("rst_vend_state", state_out, 0);
        chk("rst_vend_valid", vend_valid, 0);
        chk("rst_vend_coin", coin_out_valid, 0);
        chk("rst_vend_change", change_money, 0);
        tick();
        chk("post_rst_idle", state_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
